// File: rtl/spi_arb.sv
// Two-requester arbiter sharing one SPI_mstr16: latches requests, grants the bus, supports locked bursts.
// Optional SPI_ARB_RR_EN: round-robin tie-break instead of fixed inertial priority.
module spi_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_inrt,
  input  logic        wrt_a2d,
  input  logic [15:0] cmd_inrt,
  input  logic [15:0] cmd_a2d,
  input  logic        lock_inrt,
  input  logic        lock_a2d,
  output logic        done_inrt,
  output logic        done_a2d,
  output logic        mst_wrt,
  output logic [15:0] mst_cmd,
  input  logic        mst_done,
  output logic        owner,
  output logic        ovr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_pend_inrt;
  logic        r_pend_a2d;
  logic [15:0] r_hold_inrt;
  logic [15:0] r_hold_a2d;
  logic [7:0]  r_cnt;
  logic        r_owner;
  logic [15:0] r_mst_cmd;
  logic        r_ovr_err;

  logic        w_tie;
  logic        w_grant_a2d;
  logic        w_load_owner;
  logic        w_own_nxt;
  logic        w_pend_own;
  logic        w_lock_own;
  logic        w_issue;
  logic        w_xfer_done;

  assign w_tie      = r_pend_inrt & r_pend_a2d;
  assign w_pend_own = r_owner ? r_pend_a2d : r_pend_inrt;
  assign w_lock_own = r_owner ? lock_a2d   : lock_inrt;
  assign w_issue    = (r_state == ISSUE);

`ifdef SPI_ARB_RR_EN
  // Remembers the winner of the last tie only; single requests do not move it.
  logic r_last_a2d;

  assign w_grant_a2d = w_tie ? ~r_last_a2d : r_pend_a2d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_a2d <= 1'b1;
    end else if (w_load_owner && w_tie) begin
      r_last_a2d <= w_grant_a2d;
    end
  end
`else
  assign w_grant_a2d = r_pend_a2d & ~r_pend_inrt;
`endif

  assign w_own_nxt = (r_state == IDLE) ? w_grant_a2d : r_owner;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt  = r_state;
    w_load_owner = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pend_inrt || r_pend_a2d) begin
          w_load_owner = 1'b1;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE: w_state_nxt = XFER;
      XFER: begin
        if (mst_done) w_state_nxt = w_lock_own ? HOLD : IDLE;
      end
      HOLD: begin
        if (r_cnt == 8'hFF)   w_state_nxt = IDLE;
        else if (w_pend_own)  w_state_nxt = ISSUE;
        else if (!w_lock_own) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_owner) r_owner <= w_grant_a2d;
      r_cnt <= (r_state == HOLD) ? r_cnt + 8'd1 : 8'd0;
    end
  end

  // A request arriving while its slot is still pending is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_inrt <= 1'b0;
      r_pend_a2d  <= 1'b0;
      r_hold_inrt <= 16'h0000;
      r_hold_a2d  <= 16'h0000;
      r_ovr_err   <= 1'b0;
    end else begin
      if (w_issue && !r_owner) begin
        r_pend_inrt <= 1'b0;
      end else if (wrt_inrt && !r_pend_inrt) begin
        r_pend_inrt <= 1'b1;
        r_hold_inrt <= cmd_inrt;
      end
      if (w_issue && r_owner) begin
        r_pend_a2d <= 1'b0;
      end else if (wrt_a2d && !r_pend_a2d) begin
        r_pend_a2d <= 1'b1;
        r_hold_a2d <= cmd_a2d;
      end
      if ((wrt_inrt && r_pend_inrt) || (wrt_a2d && r_pend_a2d)) r_ovr_err <= 1'b1;
    end
  end

  // Command is captured on entry to ISSUE and then held until the next issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mst_cmd <= 16'h0000;
    end else if ((w_state_nxt == ISSUE) && (r_state != ISSUE)) begin
      r_mst_cmd <= w_own_nxt ? r_hold_a2d : r_hold_inrt;
    end
  end

  assign w_xfer_done = (r_state == XFER) & mst_done;
  assign done_inrt   = w_xfer_done & ~r_owner;
  assign done_a2d    = w_xfer_done &  r_owner;
  assign mst_wrt     = w_issue;
  assign mst_cmd     = r_mst_cmd;
  assign owner       = r_owner;
  assign ovr_err     = r_ovr_err;

endmodule

// File: tb/tb_spi_arb.sv
// Scoreboard bench for spi_arb: expected {owner, cmd} grants are queued and popped on each mst_wrt.
module tb_spi_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt_inrt = 1'b0;
  logic        wrt_a2d = 1'b0;
  logic [15:0] cmd_inrt = 16'h0000;
  logic [15:0] cmd_a2d = 16'h0000;
  logic        lock_inrt = 1'b0;
  logic        lock_a2d = 1'b0;
  logic        done_inrt;
  logic        done_a2d;
  logic        mst_wrt;
  logic [15:0] mst_cmd;
  logic        mst_done = 1'b0;
  logic        owner;
  logic        ovr_err;

  int          errors = 0;
  int          checks = 0;
  logic [16:0] sb_q[$];
  logic        exp_own = 1'b0;
  logic [15:0] exp_cmd = 16'h0000;

  spi_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrt_inrt  (wrt_inrt),
    .wrt_a2d   (wrt_a2d),
    .cmd_inrt  (cmd_inrt),
    .cmd_a2d   (cmd_a2d),
    .lock_inrt (lock_inrt),
    .lock_a2d  (lock_a2d),
    .done_inrt (done_inrt),
    .done_a2d  (done_a2d),
    .mst_wrt   (mst_wrt),
    .mst_cmd   (mst_cmd),
    .mst_done  (mst_done),
    .owner     (owner),
    .ovr_err   (ovr_err)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic own, input logic [15:0] cmd);
    sb_q.push_back({own, cmd});
  endtask

  // Waits (bounded) for mst_wrt and compares owner/command against the scoreboard head.
  task automatic expect_issue();
    int n = 0;
    logic [16:0] e;
    while (mst_wrt !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (mst_wrt !== 1'b1) begin
      errors++;
      $display("FAIL issue_wait: mst_wrt=%b after %0d cycles, required 1", mst_wrt, n);
    end else if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL issue_unexpected: owner=%b cmd=%h, required no issue", owner, mst_cmd);
    end else begin
      e = sb_q.pop_front();
      exp_own = e[16];
      exp_cmd = e[15:0];
      if ({owner, mst_cmd} !== e) begin
        errors++;
        $display("FAIL issue_data: owner=%b cmd=%h, required owner=%b cmd=%h",
                 owner, mst_cmd, e[16], e[15:0]);
      end
    end
  endtask

  // Plays the SPI master: one-cycle mst_done after dly cycles of XFER, checks done steering.
  task automatic complete(input int dly);
    logic [1:0] exp_done;
    tick();
    checks++;
    if (mst_wrt !== 1'b0) begin
      errors++;
      $display("FAIL wrt_pulse: mst_wrt=%b one cycle after issue, required 0", mst_wrt);
    end
    repeat (dly) tick();
    mst_done = 1'b1;
    #1;
    exp_done = exp_own ? 2'b01 : 2'b10;
    checks++;
    if ({done_inrt, done_a2d} !== exp_done) begin
      errors++;
      $display("FAIL done_steer: done_inrt,done_a2d=%b, required %b", {done_inrt, done_a2d}, exp_done);
    end
    tick();
    mst_done = 1'b0;
    checks++;
    if (mst_cmd !== exp_cmd) begin
      errors++;
      $display("FAIL cmd_hold: mst_cmd=%h after transfer, required %h", mst_cmd, exp_cmd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({done_inrt, done_a2d, mst_wrt, mst_cmd, owner, ovr_err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: done=%b%b wrt=%b cmd=%h owner=%b ovr=%b, required all 0",
               done_inrt, done_a2d, mst_wrt, mst_cmd, owner, ovr_err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    cmd_a2d = 16'h2000;
    wrt_a2d = 1'b1;
    push(1'b1, 16'h2000);
    tick();
    wrt_a2d = 1'b0;
    checks++;
    if (mst_wrt !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: mst_wrt=%b at N+1, required 0", mst_wrt);
    end
    tick();
    checks++;
    if (mst_wrt !== 1'b1) begin
      errors++;
      $display("FAIL latency_n2: mst_wrt=%b at N+2, required 1", mst_wrt);
    end
    expect_issue();
    complete(3);
  endtask

  task automatic test_tie();
    cmd_inrt = 16'hA5A5;
    cmd_a2d  = 16'h0800;
    wrt_inrt = 1'b1;
    wrt_a2d  = 1'b1;
    push(1'b0, 16'hA5A5);
    push(1'b1, 16'h0800);
    tick();
    wrt_inrt = 1'b0;
    wrt_a2d  = 1'b0;
    expect_issue();
    complete(2);
    expect_issue();
    complete(2);
    // Second tie: fixed priority repeats inertial; round-robin hands it to A2D.
    cmd_inrt = 16'h1111;
    cmd_a2d  = 16'h2222;
    wrt_inrt = 1'b1;
    wrt_a2d  = 1'b1;
`ifdef SPI_ARB_RR_EN
    push(1'b1, 16'h2222);
    push(1'b0, 16'h1111);
`else
    push(1'b0, 16'h1111);
    push(1'b1, 16'h2222);
`endif
    tick();
    wrt_inrt = 1'b0;
    wrt_a2d  = 1'b0;
    expect_issue();
    complete(1);
    expect_issue();
    complete(1);
  endtask

  task automatic test_lock();
    lock_a2d = 1'b1;
    cmd_a2d  = 16'h2800;
    wrt_a2d  = 1'b1;
    push(1'b1, 16'h2800);
    tick();
    wrt_a2d = 1'b0;
    expect_issue();
    complete(2);
    cmd_inrt = 16'h1234;
    wrt_inrt = 1'b1;
    tick();
    wrt_inrt = 1'b0;
    checks++;
    if (owner !== 1'b1 || mst_wrt !== 1'b0) begin
      errors++;
      $display("FAIL hold_owner: owner=%b wrt=%b during hold, required owner=1 wrt=0", owner, mst_wrt);
    end
    repeat (4) tick();
    cmd_a2d = 16'h2801;
    wrt_a2d = 1'b1;
    push(1'b1, 16'h2801);
    tick();
    wrt_a2d = 1'b0;
    expect_issue();
    complete(2);
    lock_a2d = 1'b0;
    push(1'b0, 16'h1234);
    expect_issue();
    complete(2);
    checks++;
    if (ovr_err !== 1'b0) begin
      errors++;
      $display("FAIL lock_ovr: ovr_err=%b, required 0", ovr_err);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    lock_a2d = 1'b1;
    cmd_a2d  = 16'h3000;
    wrt_a2d  = 1'b1;
    push(1'b1, 16'h3000);
    tick();
    wrt_a2d = 1'b0;
    expect_issue();
    complete(1);
    // First HOLD cycle: HOLD lasts 256 cycles, then one IDLE cycle, then ISSUE.
    cmd_inrt = 16'h4444;
    wrt_inrt = 1'b1;
    push(1'b0, 16'h4444);
    tick();
    wrt_inrt = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (mst_wrt !== 1'b0) bad++;
      if (i < 255) tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_early: mst_wrt seen %0d times inside hold window, required 0", bad);
    end
    tick();
    checks++;
    if (mst_wrt !== 1'b1) begin
      errors++;
      $display("FAIL timeout_release: mst_wrt=%b after 256 hold cycles, required 1", mst_wrt);
    end
    lock_a2d = 1'b0;
    expect_issue();
    complete(1);
  endtask

  task automatic test_overrun();
    checks++;
    if (ovr_err !== 1'b0) begin
      errors++;
      $display("FAIL ovr_pre: ovr_err=%b, required 0", ovr_err);
    end
    cmd_a2d = 16'h5555;
    wrt_a2d = 1'b1;
    push(1'b1, 16'h5555);
    tick();
    wrt_a2d = 1'b0;
    expect_issue();
    cmd_inrt = 16'h1111;
    wrt_inrt = 1'b1;
    push(1'b0, 16'h1111);
    tick();
    cmd_inrt = 16'h2222;
    tick();
    wrt_inrt = 1'b0;
    #1;
    checks++;
    if (ovr_err !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: ovr_err=%b after dropped request, required 1", ovr_err);
    end
    complete(0);
    expect_issue();
    complete(0);
    checks++;
    if (ovr_err !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: ovr_err=%b, required 1", ovr_err);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int bad = 0;
    cmd_inrt = 16'h7777;
    wrt_inrt = 1'b1;
    push(1'b0, 16'h7777);
    tick();
    wrt_inrt = 1'b0;
    expect_issue();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({done_inrt, done_a2d, mst_wrt, mst_cmd, owner, ovr_err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid: done=%b%b wrt=%b cmd=%h owner=%b ovr=%b, required all 0",
               done_inrt, done_a2d, mst_wrt, mst_cmd, owner, ovr_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    mst_done = 1'b1;
    #1;
    checks++;
    if ({done_inrt, done_a2d} !== 2'b00) begin
      errors++;
      $display("FAIL stray_done: done_inrt,done_a2d=%b, required 00", {done_inrt, done_a2d});
    end
    tick();
    mst_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mst_wrt !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_idle: mst_wrt seen %0d times, %0d grants outstanding, required 0 and 0",
               bad, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_lock();
    test_timeout();
    test_overrun();
    test_reset_mid_xfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 SHALL have port clk  input  1  50 MHz system clock.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports wrt_inrt, wrt_a2d  input  1 each  single-cycle transaction requests from the inertial and A2D requesters.
REQ-004 SHALL have ports cmd_inrt, cmd_a2d  input  16 each  command word sampled with the matching wrt.
REQ-005 SHALL have ports lock_inrt, lock_a2d  input  1 each  hold the bus for a further transaction after the current one.
REQ-006 SHALL have ports done_inrt, done_a2d  output  1 each  per-requester transaction-complete pulse.
REQ-007 SHALL have port mst_wrt  output  1  start pulse to the shared SPI_mstr16.
REQ-008 SHALL have port mst_cmd  output  16  command to SPI_mstr16.
REQ-009 SHALL have port mst_done  input  1  SPI_mstr16 done.
REQ-010 SHALL have port owner  output  1  current bus owner (0 = inertial, 1 = A2D), used to steer SS_n.
REQ-011 SHALL have port ovr_err  output  1  sticky flag: a request was dropped.

Function
REQ-012 SHALL latch each wrt_x pulse into pending_x and cmd_x into a per-requester 16-bit holding register in the same cycle.
REQ-013 SHALL ignore wrt_x while pending_x is already set (holding register unchanged) and set ovr_err.
REQ-014 SHALL implement states IDLE, ISSUE, XFER, HOLD.
REQ-015 IDLE: if any pending_x is set, SHALL select the winner per REQ-024, load owner and go to ISSUE; otherwise remain in IDLE.
REQ-016 ISSUE: SHALL assert mst_wrt for exactly one cycle with mst_cmd = owner's holding register, clear pending_owner, then go to XFER.
REQ-017 Latency: wrt_x in IDLE at cycle N SHALL produce mst_wrt at cycle N+2.
REQ-018 XFER: on mst_done, SHALL pulse done_owner combinationally in the same cycle; the other done output SHALL stay 0.
REQ-019 XFER on mst_done: if lock_owner = 1, go to HOLD; else go to IDLE.
REQ-020 HOLD: SHALL keep owner. If pending_owner is set, go to ISSUE. If lock_owner drops, go to IDLE. Requests from the non-owner SHALL stay pending.
REQ-021 HOLD SHALL run an 8-bit timeout counter, cleared on entry. At count 255 it SHALL force IDLE.
REQ-022 mst_cmd SHALL hold its value outside ISSUE.
REQ-023 Simultaneous wrt from both requesters in the same cycle SHALL set both pending flags; no request is lost.
REQ-024 Arbitration with both pending SHALL be fixed priority: inertial wins (see REQ-029).

Reset
REQ-025 On rst_n low, state SHALL go to IDLE asynchronously.
REQ-026 On rst_n low, the following SHALL be 0: pending flags, holding registers, timeout counter, owner, mst_wrt, mst_cmd, done outputs, ovr_err.
REQ-027 Reset asserted mid-XFER SHALL abandon the transaction. A later mst_done SHALL be ignored in IDLE.
REQ-028 ovr_err SHALL be cleared only by reset.

Configuration
REQ-029 Macro SPI_ARB_RR_EN: when defined, ties SHALL alternate round-robin, with the last granted requester losing the next tie; the last-granted register resets to A2D, so inertial wins the first tie. When undefined, REQ-024 fixed priority applies.

Verification
REQ-030 Single request: wrt_a2d with cmd_a2d=16'h2000 in IDLE -> mst_wrt 2 cycles later with mst_cmd=16'h2000, owner=1; mst_done -> done_a2d pulse, done_inrt=0.
REQ-031 Simultaneous requests: wrt_inrt (16'hA5A5) and wrt_a2d (16'h0800) in the same cycle -> inertial first, then A2D. With SPI_ARB_RR_EN, a second tie grants A2D first.
REQ-032 Lock sequence: A2D with lock_a2d=1 issues 16'h2800, then wrt_inrt during HOLD, then A2D's second wrt 5 cycles later -> A2D's second transaction precedes inertial's.
REQ-033 Lock timeout: lock_a2d held with no wrt_a2d for 256 cycles in HOLD -> IDLE, pending inertial request granted.
REQ-034 Overrun and reset: two wrt_inrt while busy -> ovr_err=1, first cmd kept; rst_n low mid-XFER -> all outputs 0, stray mst_done ignored.
